// File: rtl/board_gpio_io.sv
// Board GPIO front end: 2-FF sync + debounce on switches, mode-driven LED drive.
// Latency: switch pin -> sw_o in 2 + DEBOUNCE_CYCLES edges; led_i/mode/duty -> led_pin_o in 1 edge.
// Backpressure: none; free-running datapath, every input sampled every cycle.
//
// Ports:
//   clk_i       system clock
//   arst_i      asynchronous reset, active high
//   sw_pin_i    raw (asynchronous) switch pins
//   sw_o        debounced switch state
//   sw_chg_o    one-cycle pulse per channel in the first cycle sw_o shows a new value
//   led_i       LED values from the CPU
//   led_mode_i  per-LED mode, bits [2i+1:2i]: 00 direct, 01 blink, 10 dim, 11 dim-blink
//   pwm_duty_i  global dimming duty
//   led_pin_o   registered LED pin drive
module board_gpio_io #(
    parameter int SW_WIDTH        = 16,
    parameter int LED_WIDTH       = 16,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int BLINK_DIV       = 24,
    parameter int PWM_BITS        = 8
) (
    input  logic                   clk_i,
    input  logic                   arst_i,
    input  logic [SW_WIDTH-1:0]    sw_pin_i,
    output logic [SW_WIDTH-1:0]    sw_o,
    output logic [SW_WIDTH-1:0]    sw_chg_o,
    input  logic [LED_WIDTH-1:0]   led_i,
    input  logic [2*LED_WIDTH-1:0] led_mode_i,
    input  logic [PWM_BITS-1:0]    pwm_duty_i,
    output logic [LED_WIDTH-1:0]   led_pin_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // ---------------- switch path ----------------
    logic [SW_WIDTH-1:0] sync1_q, sync2_q;
    logic [SW_WIDTH-1:0] sw_q, sw_d;
    logic [SW_WIDTH-1:0] chg_q, chg_d;
    logic [CW-1:0]       cnt_q [SW_WIDTH];
    logic [CW-1:0]       cnt_d [SW_WIDTH];

    always_comb begin
        sw_d  = sw_q;
        chg_d = '0;
        for (int i = 0; i < SW_WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == sw_q[i]) begin
                // Input agrees with accepted state: any partial count was a glitch.
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                // This is the DEBOUNCE_CYCLES-th consecutive differing cycle.
                sw_d[i]  = sync2_q[i];
                chg_d[i] = 1'b1;
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sw_q    <= '0;
            chg_q   <= '0;
            for (int i = 0; i < SW_WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= sw_pin_i;
            sync2_q <= sync1_q;
            sw_q    <= sw_d;
            chg_q   <= chg_d;
            for (int i = 0; i < SW_WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign sw_o     = sw_q;
    assign sw_chg_o = chg_q;

    // ---------------- LED path ----------------
    logic [BLINK_DIV-1:0] blink_cnt_q;
    logic [PWM_BITS-1:0]  pwm_cnt_q;
    logic [LED_WIDTH-1:0] led_q, led_d;
    logic                 blink_ph;
    logic                 pwm_on;

    assign blink_ph = blink_cnt_q[BLINK_DIV-1];
    // Strict compare: duty 0 never lights, max duty leaves one dark cycle per period.
    assign pwm_on   = (pwm_cnt_q < pwm_duty_i);

    always_comb begin
        led_d = '0;
        for (int i = 0; i < LED_WIDTH; i++) begin
            case (led_mode_i[2*i +: 2])
                2'b00:   led_d[i] = led_i[i];
                2'b01:   led_d[i] = led_i[i] & blink_ph;
                2'b10:   led_d[i] = led_i[i] & pwm_on;
                default: led_d[i] = led_i[i] & blink_ph & pwm_on;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            blink_cnt_q <= '0;
            pwm_cnt_q   <= '0;
            led_q       <= '0;
        end else begin
            blink_cnt_q <= blink_cnt_q + BLINK_DIV'(1);
            pwm_cnt_q   <= pwm_cnt_q + PWM_BITS'(1);
            led_q       <= led_d;
        end
    end

    assign led_pin_o = led_q;

endmodule

// File: tb/tb_board_gpio_io.sv
// Testbench for board_gpio_io with small parameters.
// Latency: n/a.
// Backpressure: n/a.
module tb_board_gpio_io;

    logic       clk_i = 1'b0;
    logic       arst_i;
    logic [3:0] sw_pin_i;
    logic [3:0] sw_o;
    logic [3:0] sw_chg_o;
    logic [3:0] led_i;
    logic [7:0] led_mode_i;
    logic [2:0] pwm_duty_i;
    logic [3:0] led_pin_o;

    int tests = 0;
    int fails = 0;

    board_gpio_io #(
        .SW_WIDTH(4), .LED_WIDTH(4), .DEBOUNCE_CYCLES(4), .BLINK_DIV(4), .PWM_BITS(3)
    ) dut (
        .clk_i(clk_i), .arst_i(arst_i), .sw_pin_i(sw_pin_i), .sw_o(sw_o),
        .sw_chg_o(sw_chg_o), .led_i(led_i), .led_mode_i(led_mode_i),
        .pwm_duty_i(pwm_duty_i), .led_pin_o(led_pin_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0] led;
        logic [7:0] mode;
        logic [2:0] duty;
        logic [3:0] exp_led;
        logic [3:0] exp_sw;
        logic [3:0] exp_chg;
    } vec_t;

    vec_t vt [16];

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        int c0, c1, c2, c3;

        // Entry j is applied before the (j+1)-th edge after reset release, so the
        // blink/pwm counters hold j: blink_ph = j[3], pwm = j[2:0].
        vt[0]  = '{4'hF, 8'hE4, 3'd3, 4'h5, 4'h0, 4'h0};
        vt[1]  = '{4'hF, 8'hE4, 3'd3, 4'h5, 4'h0, 4'h0};
        vt[2]  = '{4'hF, 8'hE4, 3'd3, 4'h5, 4'h0, 4'h0};
        vt[3]  = '{4'hF, 8'hE4, 3'd3, 4'h1, 4'h0, 4'h0};
        vt[4]  = '{4'hF, 8'hE4, 3'd0, 4'h1, 4'h0, 4'h0};
        vt[5]  = '{4'hF, 8'hE4, 3'd7, 4'h5, 4'hF, 4'hF};
        vt[6]  = '{4'hF, 8'hE4, 3'd7, 4'h5, 4'hF, 4'h0};
        vt[7]  = '{4'hF, 8'hE4, 3'd7, 4'h1, 4'hF, 4'h0};
        vt[8]  = '{4'hF, 8'hE4, 3'd0, 4'h3, 4'hF, 4'h0};
        vt[9]  = '{4'hF, 8'hE4, 3'd3, 4'hF, 4'hF, 4'h0};
        vt[10] = '{4'hA, 8'hE4, 3'd3, 4'hA, 4'hF, 4'h0};
        vt[11] = '{4'hF, 8'h00, 3'd3, 4'hF, 4'hF, 4'h0};
        vt[12] = '{4'hF, 8'hFF, 3'd7, 4'hF, 4'hF, 4'h0};
        vt[13] = '{4'hF, 8'hFF, 3'd5, 4'h0, 4'hF, 4'h0};
        vt[14] = '{4'hF, 8'h55, 3'd0, 4'hF, 4'hF, 4'h0};
        vt[15] = '{4'hF, 8'hAA, 3'd7, 4'h0, 4'hF, 4'h0};

        // Reset with pins and LEDs high: everything must stay 0.
        arst_i = 1'b1; sw_pin_i = 4'hF; led_i = 4'hF; led_mode_i = 8'h00; pwm_duty_i = 3'd0;
        step(); step();
        check("reset_sw", 32'(sw_o), 32'h0);
        check("reset_chg", 32'(sw_chg_o), 32'h0);
        check("reset_led", 32'(led_pin_o), 32'h0);
        arst_i = 1'b0;

        // LED modes/duty vectors; switches (held high) debounce in parallel.
        for (int j = 0; j < 16; j++) begin
            led_i = vt[j].led; led_mode_i = vt[j].mode; pwm_duty_i = vt[j].duty;
            step();
            check($sformatf("vec%0d_led", j), 32'(led_pin_o), 32'(vt[j].exp_led));
            check($sformatf("vec%0d_sw", j), 32'(sw_o), 32'(vt[j].exp_sw));
            check($sformatf("vec%0d_chg", j), 32'(sw_chg_o), 32'(vt[j].exp_chg));
        end

        // Return switches to 0.
        sw_pin_i = 4'h0;
        for (int k = 0; k < 7; k++) step();
        check("sw_clear", 32'(sw_o), 32'h0);
        check("sw_clear_chg", 32'(sw_chg_o), 32'h0);

        // Single channel rise: accepted on the 6th edge (2 sync + 4 debounce).
        sw_pin_i = 4'h1;
        for (int k = 1; k <= 7; k++) begin
            step();
            check($sformatf("rise0_sw_s%0d", k), 32'(sw_o), (k >= 6) ? 32'h1 : 32'h0);
            check($sformatf("rise0_chg_s%0d", k), 32'(sw_chg_o), (k == 6) ? 32'h1 : 32'h0);
        end

        // 3-cycle glitch on channel 1: rejected.
        sw_pin_i = 4'h3;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 3) sw_pin_i = 4'h1;
            check($sformatf("glitch3_sw_s%0d", k), 32'(sw_o), 32'h1);
            check($sformatf("glitch3_chg_s%0d", k), 32'(sw_chg_o), 32'h0);
        end

        // 4-cycle pulse on channel 1: accepted, then debounced back to 0.
        sw_pin_i = 4'h3;
        for (int k = 1; k <= 11; k++) begin
            step();
            if (k == 4) sw_pin_i = 4'h1;
            check($sformatf("pulse4_sw_s%0d", k), 32'(sw_o),
                  (k >= 6 && k <= 9) ? 32'h3 : 32'h1);
            check($sformatf("pulse4_chg_s%0d", k), 32'(sw_chg_o),
                  (k == 6 || k == 10) ? 32'h2 : 32'h0);
        end

        // All four channels change in the same cycle.
        sw_pin_i = 4'hE;
        for (int k = 1; k <= 7; k++) begin
            step();
            check($sformatf("simul_sw_s%0d", k), 32'(sw_o), (k >= 6) ? 32'hE : 32'h1);
            check($sformatf("simul_chg_s%0d", k), 32'(sw_chg_o), (k == 6) ? 32'hF : 32'h0);
        end

        // Reset mid-debounce.
        led_i = 4'hF; led_mode_i = 8'h00;
        step();
        check("pre_rst_led", 32'(led_pin_o), 32'hF);
        sw_pin_i = 4'h1;
        step(); step(); step();
        #1 arst_i = 1'b1;
        #1;
        check("midrst_sw", 32'(sw_o), 32'h0);
        check("midrst_chg", 32'(sw_chg_o), 32'h0);
        check("midrst_led", 32'(led_pin_o), 32'h0);
        step(); step();
        check("inrst_led", 32'(led_pin_o), 32'h0);
        check("inrst_sw", 32'(sw_o), 32'h0);
        arst_i = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            check($sformatf("postrst_sw_s%0d", k), 32'(sw_o), (k >= 6) ? 32'h1 : 32'h0);
            check($sformatf("postrst_chg_s%0d", k), 32'(sw_chg_o), (k == 6) ? 32'h1 : 32'h0);
            check($sformatf("postrst_led_s%0d", k), 32'(led_pin_o), 32'hF);
        end

        // Duty-cycle counts over whole periods.
        led_mode_i = 8'hE4; pwm_duty_i = 3'd3;
        c0 = 0; c1 = 0; c2 = 0; c3 = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            c0 += int'(led_pin_o[0]); c1 += int'(led_pin_o[1]);
            c2 += int'(led_pin_o[2]); c3 += int'(led_pin_o[3]);
            check($sformatf("led3_and_s%0d", k), 32'(led_pin_o[3]),
                  32'(led_pin_o[1] & led_pin_o[2]));
        end
        check("cnt_direct", 32'(c0), 32'd16);
        check("cnt_blink", 32'(c1), 32'd8);
        check("cnt_dim3", 32'(c2), 32'd6);
        check("cnt_dimblink", 32'(c3), 32'd3);

        led_mode_i = 8'hAA; pwm_duty_i = 3'd0;
        c0 = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            c0 += (led_pin_o != 4'h0) ? 1 : 0;
        end
        check("cnt_duty0", 32'(c0), 32'd0);

        pwm_duty_i = 3'd7;
        c0 = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            c0 += int'(led_pin_o[0]);
        end
        check("cnt_duty7", 32'(c0), 32'd7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
